// File: rtl/note_sequencer.sv
// Pattern-driven step sequencer feeding tone_freq/gate of one voice; outputs are registered,
// a step load (strobe, pitch, gate) appears on the same edge that samples run or ends a step.
module note_sequencer #(
  parameter int STEPS  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [15:0]       tempo,
  input  logic [15:0]       gate_len,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [6:0]        wr_note,
  output logic [15:0]       tone_freq,
  output logic              gate,
  output logic [STEP_W-1:0] step_idx,
  output logic              step_strobe
);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t            state, state_nxt;
  logic [6:0]        pattern [STEPS];
  logic [15:0]       pos, pos_nxt;
  logic [15:0]       t_last, gate_lim;
  logic              step_end;
  logic [STEP_W-1:0] idx_nxt, load_idx;
  logic [6:0]        load_note;
  logic              load_valid, load;
  logic              cur_valid, cur_valid_nxt;
  logic [15:0]       freq_nxt;
  logic              gate_nxt, strobe_nxt;

  function automatic logic note_valid(input logic [6:0] n);
    return (n != 7'd0) && (n < 7'd96);
  endfunction

  // BASE holds the MIDI 96..107 increments; lower octaves are right shifts of it.
  function automatic logic [15:0] conv(input logic [6:0] n);
    logic [3:0]  oct;
    logic [3:0]  semi;
    logic [16:0] b;
    oct  = 4'(n / 7'd12);
    semi = 4'(n % 7'd12);
    case (semi)
      4'd0:    b = 17'd35115;
      4'd1:    b = 17'd37203;
      4'd2:    b = 17'd39415;
      4'd3:    b = 17'd41759;
      4'd4:    b = 17'd44242;
      4'd5:    b = 17'd46873;
      4'd6:    b = 17'd49660;
      4'd7:    b = 17'd52613;
      4'd8:    b = 17'd55741;
      4'd9:    b = 17'd59056;
      4'd10:   b = 17'd62567;
      default: b = 17'd66288;
    endcase
    return 16'(b >> (4'd8 - oct));
  endfunction

  always_comb begin
    t_last     = (tempo < 16'd3) ? 16'd1 : tempo - 16'd1;
    gate_lim   = (gate_len < t_last) ? gate_len : t_last;
    step_end   = (pos >= t_last);
    load_idx   = (state == IDLE) ? '0 : step_idx + STEP_W'(1);
    load_note  = pattern[load_idx];
    load_valid = note_valid(load_note);
  end

  always_comb begin
    state_nxt     = state;
    pos_nxt       = pos;
    idx_nxt       = step_idx;
    freq_nxt      = tone_freq;
    gate_nxt      = gate;
    strobe_nxt    = 1'b0;
    cur_valid_nxt = cur_valid;
    load          = 1'b0;
    case (state)
      IDLE: begin
        pos_nxt  = '0;
        idx_nxt  = '0;
        gate_nxt = 1'b0;
        if (run) begin
          state_nxt = PLAY;
          load      = 1'b1;
        end
      end
      PLAY: begin
        if (!run) begin
          state_nxt     = IDLE;
          pos_nxt       = '0;
          idx_nxt       = '0;
          gate_nxt      = 1'b0;
          cur_valid_nxt = 1'b0;
        end else if (step_end) begin
          // A shrinking tempo can leave pos beyond the new last clock; end the step anyway.
          pos_nxt = '0;
          idx_nxt = load_idx;
          load    = 1'b1;
        end else begin
          pos_nxt  = pos + 16'd1;
          gate_nxt = cur_valid && ((pos + 16'd1) < gate_lim);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      strobe_nxt    = 1'b1;
      cur_valid_nxt = load_valid;
      gate_nxt      = load_valid && (gate_len != 16'd0);
      if (load_valid) freq_nxt = conv(load_note);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pos         <= '0;
      step_idx    <= '0;
      tone_freq   <= '0;
      gate        <= 1'b0;
      step_strobe <= 1'b0;
      cur_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      step_idx    <= idx_nxt;
      tone_freq   <= freq_nxt;
      gate        <= gate_nxt;
      step_strobe <= strobe_nxt;
      cur_valid   <= cur_valid_nxt;
    end
  end

  // Same-entry write and load: the load above sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
    end else if (wr_en) begin
      pattern[wr_addr] <= wr_note;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected steps are queued before play and
// compared on each step_strobe, with period and gate-high time measured per step.
module tb_note_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] tempo;
  logic [15:0] gate_len;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [6:0]  wr_note;
  logic [15:0] tone_freq;
  logic        gate;
  logic [3:0]  step_idx;
  logic        step_strobe;

  typedef struct {
    int idx;
    int freq;
    int ghigh;
    int period;
  } step_t;

  step_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  note_sequencer #(.STEPS(16), .STEP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .tempo      (tempo),
    .gate_len   (gate_len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_note    (wr_note),
    .tone_freq  (tone_freq),
    .gate       (gate),
    .step_idx   (step_idx),
    .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input int freq, input int ghigh, input int period);
    step_t s;
    s.idx = idx; s.freq = freq; s.ghigh = ghigh; s.period = period;
    exp_q.push_back(s);
  endtask

  task automatic write_note(input logic [3:0] a, input logic [6:0] n);
    wr_en = 1'b1; wr_addr = a; wr_note = n;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Plays until the queue is drained and the final (period 0) step has begun.
  // wr_at selects the edge index (0 = start edge) at which a pattern write lands.
  task automatic play(input int wr_at, input logic [3:0] wa, input logic [6:0] wn);
    step_t cur;
    int    last_c;
    int    gcnt;
    bit    have;
    bit    done;
    cur = '{default: 0};
    last_c = 0; gcnt = 0; have = 1'b0; done = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 2000 && !done; c++) begin
      wr_en = (c == wr_at); wr_addr = wa; wr_note = wn;
      @(negedge clk);
      if (c == 0) chk("start_strobe", step_strobe, 1);
      if (step_strobe) begin
        if (have && cur.period != 0) begin
          chk("period", c - last_c, cur.period);
          chk("gate_clks", gcnt, cur.ghigh);
        end
        if (exp_q.size() == 0) begin
          chk("strobe_expected", exp_q.size(), 1);
          done = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          have = 1'b1; last_c = c; gcnt = 0;
          chk("step_idx", step_idx, cur.idx);
          chk("tone_freq", tone_freq, cur.freq);
        end
      end
      gcnt += int'(gate);
      if (have && exp_q.size() == 0 && cur.period == 0 && c > last_c) done = 1'b1;
    end
    wr_en = 1'b0;
    chk("play_done", done, 1);
  endtask

  task automatic stop_check(input int freq);
    run = 1'b0;
    @(negedge clk);
    chk("stop_gate", gate, 0);
    chk("stop_idx", step_idx, 0);
    chk("stop_strobe", step_strobe, 0);
    chk("stop_freq", tone_freq, freq);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; tempo = 16'd10; gate_len = 16'd4;
    wr_en = 1'b0; wr_addr = '0; wr_note = '0;
    repeat (2) @(negedge clk);
    chk("rst_freq", tone_freq, 0);
    chk("rst_gate", gate, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_strobe", step_strobe, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic step: A4 at tempo 10, gate 4, then a rest that keeps the pitch.
    write_note(4'd0, 7'd69);
    tempo = 16'd10; gate_len = 16'd4;
    push(0, 7382, 4, 10);
    push(1, 7382, 0, 0);
    play(-1, 4'd0, 7'd0);
    stop_check(7382);

    // Conversion sweep including both kinds of rest.
    write_note(4'd0, 7'd12);
    write_note(4'd1, 7'd60);
    write_note(4'd2, 7'd95);
    write_note(4'd3, 7'd0);
    write_note(4'd4, 7'd100);
    tempo = 16'd4; gate_len = 16'd2;
    push(0, 274, 2, 4);
    push(1, 4389, 2, 4);
    push(2, 33144, 2, 4);
    push(3, 33144, 0, 4);
    push(4, 33144, 0, 0);
    play(-1, 4'd0, 7'd0);
    stop_check(33144);

    // Full lap with wrap; gate clipped to T-1 for retrigger.
    for (int i = 0; i < 16; i++) write_note(4'(i), 7'd60);
    tempo = 16'd5; gate_len = 16'd100;
    for (int i = 0; i < 16; i++) push(i, 4389, 4, 5);
    push(0, 4389, 0, 0);
    play(-1, 4'd0, 7'd0);
    stop_check(4389);

    // Degenerate tempos collapse to a 2-clock step.
    for (int t = 0; t < 2; t++) begin
      tempo = 16'(t); gate_len = 16'd0;
      for (int i = 0; i < 4; i++) push(i, 4389, 0, 2);
      push(4, 4389, 0, 0);
      play(-1, 4'd0, 7'd0);
      stop_check(4389);
    end

    // Write to step 3 on the very edge it loads: old note now, new note next lap.
    tempo = 16'd5; gate_len = 16'd2;
    for (int i = 0; i < 16; i++) push(i, 4389, 2, 5);
    for (int i = 0; i < 3; i++) push(i, 4389, 2, 5);
    push(3, 8778, 0, 0);
    play(15, 4'd3, 7'd72);
    stop_check(8778);

    // Asynchronous reset in the middle of a gate.
    write_note(4'd0, 7'd60);
    tempo = 16'd10; gate_len = 16'd6;
    push(0, 4389, 0, 0);
    play(-1, 4'd0, 7'd0);
    chk("gate_before_rst", gate, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_freq", tone_freq, 0);
    chk("arst_gate", gate, 0);
    chk("arst_idx", step_idx, 0);
    chk("arst_strobe", step_strobe, 0);
    @(negedge clk);
    chk("arst_hold_strobe", step_strobe, 0);
    #2 rst_n = 1'b1;
    push(0, 0, 0, 10);
    push(1, 0, 0, 0);
    play(-1, 4'd0, 7'd0);
    stop_check(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
